// File: rtl/hazard_detect_pkg.sv
// Shared definitions for the decode-stage hazard detection unit:
// default widths, the branch opcode prefix, and the tracker entry layout.
package hazard_detect_pkg;

   localparam int unsigned AW          = 5;
   localparam int unsigned TRACK_DEPTH = 4;

   // Opcodes 6'h10..6'h13 are branches.
   localparam logic [3:0] BRANCH_PREFIX = 4'b0100;

   // One in-flight writer: destination register and whether it really writes.
   typedef struct packed {
      logic          valid;
      logic [AW-1:0] addr;
   } trk_entry_t;

   function automatic logic is_branch(input logic [3:0] op_hi);
      return op_hi == BRANCH_PREFIX;
   endfunction

endpackage

// File: rtl/hazard_dest_pipe.sv
// Destination tracker: a DEPTH-slot shift register of {valid, addr} for writers
// that have left decode, compared against both decode read ports.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   push_valid, push_addr writer leaving decode this cycle
//   rd_addr1/2, rd_en1/2  decode-stage read ports
//   match_c               combinational: an enabled read hits a tracked writer
module hazard_dest_pipe #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_valid,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic              rd_en1,
   input  logic [ADDR_W-1:0] rd_addr2,
   input  logic              rd_en2,
   output logic              match_c
);
   import hazard_detect_pkg::*;

   trk_entry_t entries_q [DEPTH];
   trk_entry_t entries_d [DEPTH];

   // Shift: new writer enters slot 0, the oldest slot falls off the end.
   always_comb begin
      entries_d[0].valid = push_valid;
      entries_d[0].addr  = push_addr;
      for (int i = 1; i < DEPTH; i++) begin
         entries_d[i] = entries_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

   // Only registered entries are compared, so an instruction never sees its own write.
   always_comb begin
      match_c = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries_q[i].valid &&
             ((rd_en1 && (entries_q[i].addr == rd_addr1)) ||
              (rd_en2 && (entries_q[i].addr == rd_addr2)))) begin
            match_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard_detect.sv
// Decode-stage hazard detection: RAW data hazards against in-flight writers and
// control hazards from call/return/branch held until fetch returns the clear.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   opcode                            decode opcode (branch decode only)
//   RegWrite, ALU_logic, and_add_imm  destination selection and write enable
//   load, pop_push, R_I_type_rs       present on the interface, not used
//   call, ret                         control-flow instructions in decode
//   R_type_rd, R_I_type_rt_rd         candidate destinations
//   rd_addr1/2, rd_en1/2              decode read ports
//   clr_call_haz/ret/branch           clear matching pending control hazard
//   data_hazard, control_hazard       combinational hazard outputs
module hazard_detect #(
   parameter int unsigned TRACK_DEPTH = hazard_detect_pkg::TRACK_DEPTH,
   parameter int unsigned AW          = hazard_detect_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [5:0]    opcode,
   input  logic          RegWrite,
   input  logic          ALU_logic,
   input  logic          load,
   input  logic          pop_push,
   input  logic          call,
   input  logic          ret,
   input  logic          and_add_imm,
   input  logic [AW-1:0] R_type_rd,
   input  logic [AW-1:0] R_I_type_rt_rd,
   input  logic [AW-1:0] R_I_type_rs,
   input  logic [AW-1:0] rd_addr1,
   input  logic [AW-1:0] rd_addr2,
   input  logic          rd_en1,
   input  logic          rd_en2,
   input  logic          clr_call_haz,
   input  logic          clr_ret_haz,
   input  logic          clr_branch_haz,
   output logic          data_hazard,
   output logic          control_hazard
);

   logic [AW-1:0] dest_c;
   logic          branch_c;
   logic          push_valid_c;
   logic          call_p_q, call_p_d;
   logic          ret_p_q,  ret_p_d;
   logic          br_p_q,   br_p_d;
   logic          unused_ok;

   always_comb unused_ok = ^{load, pop_push, R_I_type_rs, opcode[1:0]};

   // R-type register ALU ops write rd; immediates and everything else write rt.
   always_comb begin
      dest_c       = (ALU_logic && !and_add_imm) ? R_type_rd : R_I_type_rt_rd;
      branch_c     = hazard_detect_pkg::is_branch(opcode[5:2]);
      // A stalled or squashed decode slot becomes a bubble, not a tracked writer.
      push_valid_c = RegWrite & ~data_hazard & ~control_hazard;
   end

   // Pending control flags: a new set beats a simultaneous clear.
   always_comb begin
      call_p_d = call_p_q;
      ret_p_d  = ret_p_q;
      br_p_d   = br_p_q;
      if (call)              call_p_d = 1'b1;
      else if (clr_call_haz) call_p_d = 1'b0;
      if (ret)               ret_p_d  = 1'b1;
      else if (clr_ret_haz)  ret_p_d  = 1'b0;
      if (branch_c)            br_p_d = 1'b1;
      else if (clr_branch_haz) br_p_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         call_p_q <= 1'b0;
         ret_p_q  <= 1'b0;
         br_p_q   <= 1'b0;
      end else begin
         call_p_q <= call_p_d;
         ret_p_q  <= ret_p_d;
         br_p_q   <= br_p_d;
      end
   end

   always_comb control_hazard = call | ret | branch_c | call_p_q | ret_p_q | br_p_q;

   hazard_dest_pipe #(
      .DEPTH  (TRACK_DEPTH),
      .ADDR_W (AW)
   ) u_dest_pipe (
      .clk        (clk),
      .rst        (rst),
      .push_valid (push_valid_c),
      .push_addr  (dest_c),
      .rd_addr1   (rd_addr1),
      .rd_en1     (rd_en1),
      .rd_addr2   (rd_addr2),
      .rd_en2     (rd_en2),
      .match_c    (data_hazard)
   );

endmodule

// File: tb/tb_hazard_detect.sv
// Directed-vector bench for hazard_detect. The driver pushes the expected
// {data_hazard, control_hazard} for every cycle it drives; a monitor pops and
// compares on the falling edge.
module tb_hazard_detect;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       RegWrite, ALU_logic, load, pop_push, call, ret, and_add_imm;
   logic [4:0] R_type_rd, R_I_type_rt_rd, R_I_type_rs, rd_addr1, rd_addr2;
   logic       rd_en1, rd_en2;
   logic       clr_call_haz, clr_ret_haz, clr_branch_haz;
   logic       data_hazard, control_hazard;

   typedef struct {
      string nm;
      logic  dh;
      logic  ch;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   hazard_detect dut (
      .clk            (clk),
      .rst            (rst),
      .opcode         (opcode),
      .RegWrite       (RegWrite),
      .ALU_logic      (ALU_logic),
      .load           (load),
      .pop_push       (pop_push),
      .call           (call),
      .ret            (ret),
      .and_add_imm    (and_add_imm),
      .R_type_rd      (R_type_rd),
      .R_I_type_rt_rd (R_I_type_rt_rd),
      .R_I_type_rs    (R_I_type_rs),
      .rd_addr1       (rd_addr1),
      .rd_addr2       (rd_addr2),
      .rd_en1         (rd_en1),
      .rd_en2         (rd_en2),
      .clr_call_haz   (clr_call_haz),
      .clr_ret_haz    (clr_ret_haz),
      .clr_branch_haz (clr_branch_haz),
      .data_hazard    (data_hazard),
      .control_hazard (control_hazard)
   );

   task automatic clr_in();
      opcode = 6'h00; RegWrite = 0; ALU_logic = 0; load = 0; pop_push = 0;
      call = 0; ret = 0; and_add_imm = 0;
      R_type_rd = 0; R_I_type_rt_rd = 0; R_I_type_rs = 0;
      rd_addr1 = 0; rd_addr2 = 0; rd_en1 = 0; rd_en2 = 0;
      clr_call_haz = 0; clr_ret_haz = 0; clr_branch_haz = 0;
   endtask

   // Record expectation for the inputs currently driven, then advance one cycle.
   task automatic cyc(input string nm, input logic edh, input logic ech);
      exp_t e;
      e.nm = nm; e.dh = edh; e.ch = ech;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      clr_in();
   endtask

   task automatic alu_wr(input logic [4:0] rd);
      RegWrite = 1; ALU_logic = 1; and_add_imm = 0; R_type_rd = rd;
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_vec++;
         if (data_hazard !== mon_e.dh || control_hazard !== mon_e.ch) begin
            n_fail++;
            $display("FAIL %s: got data_hazard=%b control_hazard=%b, expected %b %b",
                     mon_e.nm, data_hazard, control_hazard, mon_e.dh, mon_e.ch);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      clr_in();
      repeat (2) @(posedge clk);
      #1;
      cyc("reset", 0, 0);
      rst = 1'b1;

      // Basic RAW window: write r2, read r2 for five cycles; r9 is the unused I-type dest.
      alu_wr(5'd2); R_I_type_rt_rd = 5'd9;
      cyc("t1_write", 0, 0);
      for (int k = 1; k <= 4; k++) begin
         rd_addr1 = 5'd2; rd_en1 = 1;
         cyc("t1_read_r2", 1, 0);
      end
      rd_addr1 = 5'd2; rd_en1 = 1; rd_addr2 = 5'd9; rd_en2 = 1;
      cyc("t1_window_end", 0, 0);

      // Same-cycle write and read never self-hazards.
      alu_wr(5'd1); rd_addr1 = 5'd1; rd_en1 = 1;
      cyc("t2_same_cycle", 0, 0);
      for (int k = 1; k <= 4; k++) begin
         rd_addr1 = 5'd1; rd_en1 = 1;
         cyc("t2_read_r1", 1, 0);
      end
      rd_addr1 = 5'd1; rd_en1 = 1;
      cyc("t2_window_end", 0, 0);

      // Immediate form writes rt (r4), then I-type r3; read r4 on port 2 only.
      RegWrite = 1; ALU_logic = 1; and_add_imm = 1; R_I_type_rt_rd = 5'd4; R_type_rd = 5'd7;
      cyc("t3_write_r4", 0, 0);
      RegWrite = 1; R_I_type_rt_rd = 5'd3;
      cyc("t3_write_r3", 0, 0);
      for (int k = 2; k <= 4; k++) begin
         rd_addr2 = 5'd4; rd_en2 = 1; rd_addr1 = 5'd4; rd_en1 = 0;
         cyc("t3_port2_r4", 1, 0);
      end
      rd_addr2 = 5'd4; rd_en2 = 1;
      cyc("t3_window_end", 0, 0);

      // Disabled read port never hazards.
      alu_wr(5'd4);
      cyc("t4_write_r4", 0, 0);
      rd_addr2 = 5'd4; rd_en2 = 0;
      cyc("t4_en2_low", 0, 0);
      rd_addr2 = 5'd4; rd_en2 = 1;
      cyc("t4_en2_high", 1, 0);
      repeat (3) cyc("t4_drain", 0, 0);

      // Stalled decode instruction's write is dropped.
      alu_wr(5'd5);
      cyc("t5_write_r5", 0, 0);
      alu_wr(5'd6); rd_addr1 = 5'd5; rd_en1 = 1;
      cyc("t5_stalled", 1, 0);
      rd_addr1 = 5'd6; rd_en1 = 1;
      cyc("t5_dropped_r6", 0, 0);
      repeat (3) cyc("t5_drain", 0, 0);

      // Call held until clr_call_haz; a write during the hazard is squashed.
      call = 1;
      cyc("t6_call", 0, 1);
      alu_wr(5'd8);
      cyc("t6_pend", 0, 1);
      repeat (2) cyc("t6_pend", 0, 1);
      clr_call_haz = 1;
      cyc("t6_clear_cycle", 0, 1);
      rd_addr1 = 5'd8; rd_en1 = 1;
      cyc("t6_after_clear", 0, 0);

      // Branch with simultaneous clear: set wins.
      opcode = 6'h12; clr_branch_haz = 1;
      cyc("t7_branch_12", 0, 1);
      cyc("t7_set_wins", 0, 1);
      cyc("t7_pend", 0, 1);
      clr_branch_haz = 1;
      cyc("t7_clear_cycle", 0, 1);
      opcode = 6'h14;
      cyc("t7_op14_not_branch", 0, 0);
      opcode = 6'h0F;
      cyc("t7_op0f_not_branch", 0, 0);
      opcode = 6'h13;
      cyc("t7_branch_13", 0, 1);
      clr_branch_haz = 1;
      cyc("t7_clear13", 0, 1);
      cyc("t7_idle", 0, 0);

      // Return is only cleared by its own clear.
      ret = 1;
      cyc("t8_ret", 0, 1);
      clr_call_haz = 1;
      cyc("t8_wrong_clear", 0, 1);
      clr_ret_haz = 1;
      cyc("t8_ret_clear", 0, 1);
      cyc("t8_idle", 0, 0);

      // Register 0 is tracked like any other.
      alu_wr(5'd0);
      cyc("t9_write_r0", 0, 0);
      rd_addr1 = 5'd0; rd_en1 = 1;
      cyc("t9_read_r0", 1, 0);
      repeat (3) cyc("t9_drain", 0, 0);

      // Async reset mid-hazard clears everything immediately.
      alu_wr(5'd10);
      cyc("t10_write_r10", 0, 0);
      call = 1; rd_addr1 = 5'd10; rd_en1 = 1;
      cyc("t10_both", 1, 1);
      rst = 1'b0; rd_addr1 = 5'd10; rd_en1 = 1;
      cyc("t10_in_reset", 0, 0);
      rst = 1'b1; rd_addr1 = 5'd10; rd_en1 = 1;
      cyc("t10_after_reset", 0, 0);

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
